dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters:
//  m0 = core load/store unit, m1 = debug/program-loader port.
//  Round-robin arbitration, one transaction in flight; the requester supplies byte strobes.
//  Sits between the core LSU / debug bridge and a 1-cycle-latency synchronous SRAM.
// PARAMETERS
//  ADDR_W     32  byte-address width of both requester ports
//  DATA_W     32  data width (byte strobes = DATA_W/8)
//  MEM_DEPTH  64  number of DATA_W words; mem_addr width = $clog2(MEM_DEPTH)
// PORTS
//  clk            in   1          rising-edge clock
//  rst_n          in   1          asynchronous active-low reset
//  mN_req_valid   in   1          N=0,1: request valid
//  mN_req_ready   out  1          request accepted this cycle
//  mN_we          in   1          1 = write, 0 = read
//  mN_addr        in   ADDR_W     byte address; [1:0] ignored (word access)
//  mN_wdata       in   DATA_W     write data, byte lanes in place
//  mN_wstrb       in   DATA_W/8   write byte enables
//  mN_rsp_valid   out  1          one-cycle response pulse
//  mN_rdata       out  DATA_W     read data (0 for writes/errors)
//  mN_rsp_err     out  1          address out of range
//  mem_en         out  1          SRAM access strobe
//  mem_we         out  1          SRAM write
//  mem_addr       out  $clog2(MEM_DEPTH)  word index
//  mem_wdata      out  DATA_W     SRAM write data
//  mem_wstrb      out  DATA_W/8   SRAM byte enables
//  mem_rdata      in   DATA_W     SRAM read data, valid the cycle after mem_en
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all outputs 0, last_grant=1 (m0 wins first).
//  FSM: IDLE -> ISSUE -> RESP -> IDLE; ERR path: IDLE -> RESP.
//  IDLE: mN_req_ready is combinational, asserted only for the winner when its valid=1.
//   - One requester valid: it wins. Both valid: the requester != last_grant wins.
//   - Accept edge: latch we/addr/wdata/wstrb/id and update last_grant=id.
//   - word index = addr[ADDR_W-1:2]. If it is >= MEM_DEPTH, set err and go to RESP,
//     else go to ISSUE.
//  ISSUE: mem_en=1 for exactly one cycle; mem_we/addr/wdata/wstrb come from the latch.
//   - mem_wstrb=0 when mem_we=0.
//  RESP: mN_rsp_valid=1 for one cycle (granted id only).
//   - Read: rdata=mem_rdata. Write or err: rdata=0.
//   - rsp_err=err. Returns to IDLE.
//  Latency: accepted at edge T -> mem_en cycle T..T+1 -> rsp cycle T+1..T+2.
//   - Throughput: one transaction per 3 cycles; err costs 2.
//  No response backpressure: requesters must accept rsp_valid when pulsed.
//  req_ready=0 in ISSUE/RESP. Requests held by the requester are not lost; they are taken
//   at the next IDLE.
//  Non-granted rsp_valid/rdata/rsp_err=0 at all times. mem_* outputs are 0 outside ISSUE.
//  Out-of-range requests never assert mem_en.
//  Reset mid-transaction: the transaction is dropped, with no rsp pulse and no mem_en.
//  Memory is unchanged unless the edge with mem_en=1 has already occurred.
//  Valid dropped before acceptance: treated as never requested.
// TESTING
//  1 m0 write 0x12345678 @0xFC, wstrb 1111, then read @0xFC -> mem_addr=63; read rsp
//    rdata=0x12345678, err=0, rsp_valid exactly 2 cycles after accept.
//  2 m0 write 0x0000FFFF @0xF8, wstrb 0011 -> mem_wstrb=0011, mem_addr=62;
//    m0 read -> low half=FFFF.
//  3 both valid first cycle after reset -> m0 granted first, m1 next IDLE; both held
//    continuously -> grants alternate m0,m1,m0,m1 over 4 transactions.
//  4 m1 read @0x100 (index 64, MEM_DEPTH=64) -> no mem_en, m1_rsp_err=1, rdata=0,
//    rsp 1 cycle after accept.
//  5 rst_n low during ISSUE of m0 write -> all outputs 0 immediately; no rsp pulse;
//    after release, both valid -> m0 granted.
//  6 m1 read while m0 idle -> m0_rsp_valid stays 0; m1_rdata matches SRAM model.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-port 1-cycle SRAM between two requesters
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_DEPTH = 64,
  localparam int SW = DATA_W / 8,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [SW-1:0]     m0_wstrb,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rsp_err,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [SW-1:0]     m1_wstrb,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [SW-1:0]     mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, id, acc, oor, iss, rsp;
  logic l_id, l_we, l_err;
  logic [AW-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata, rdata_r;
  logic [SW-1:0] l_wstrb;
  logic [ADDR_W-1:0] idx;
  // grant selection, range check and all outputs; ready is masked while reset is held so every output is 0
  always_comb begin
    id = (m0_req_valid & m1_req_valid) ? ~last_grant : ~m0_req_valid;
    acc = (state == IDLE) & (m0_req_valid | m1_req_valid) & rst_n;
    idx = (id ? m1_addr : m0_addr) >> 2;
    oor = idx >= ADDR_W'(MEM_DEPTH);
    state_nx = state == IDLE ? (acc ? (oor ? RESP : ISSUE) : IDLE) : state == ISSUE ? RESP : IDLE;
    iss = state == ISSUE;
    rsp = state == RESP;
    m0_req_ready = acc & ~id;
    m1_req_ready = acc & id;
    mem_en = iss;
    mem_we = iss & l_we;
    mem_addr = iss ? l_addr : '0;
    mem_wdata = iss ? l_wdata : '0;
    mem_wstrb = (iss & l_we) ? l_wstrb : '0;
    rdata_r = (rsp & ~l_we & ~l_err) ? mem_rdata : '0;
    m0_rsp_valid = rsp & ~l_id;
    m1_rsp_valid = rsp & l_id;
    m0_rsp_err = rsp & ~l_id & l_err;
    m1_rsp_err = rsp & l_id & l_err;
    m0_rdata = l_id ? '0 : rdata_r;
    m1_rdata = l_id ? rdata_r : '0;
  end
  // state register; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // capture the winning request and remember who was served for round-robin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      l_id <= 1'b0;
      l_we <= 1'b0;
      l_err <= 1'b0;
      l_addr <= '0;
      l_wdata <= '0;
      l_wstrb <= '0;
    end else if (acc) begin
      last_grant <= id;
      l_id <= id;
      l_we <= id ? m1_we : m0_we;
      l_err <= oor;
      l_addr <= idx[AW-1:0];
      l_wdata <= id ? m1_wdata : m0_wdata;
      l_wstrb <= id ? m1_wstrb : m0_wstrb;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus scoreboard checks of dmem_arbiter against an SRAM model
module tb_dmem_arbiter;
  logic clk = 0, rst_n = 0;
  logic m0_req_valid = 0, m0_req_ready, m0_we = 0, m0_rsp_valid, m0_rsp_err;
  logic m1_req_valid = 0, m1_req_ready, m1_we = 0, m1_rsp_valid, m1_rsp_err;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m0_rdata, m1_addr = 0, m1_wdata = 0, m1_rdata;
  logic [3:0] m0_wstrb = 0, m1_wstrb = 0, mem_wstrb;
  logic mem_en, mem_we;
  logic [5:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] sram [64];

  typedef struct {
    logic id; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    logic [31:0] rdata; logic err; logic [5:0] maddr;
  } vec_t;
  typedef struct { logic id; logic [31:0] rdata; logic err; int cyc; } exp_t;
  exp_t q[$];
  exp_t e;
  vec_t tbl[12];
  int n_vec = 0, n_bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_en) begin
    for (int b = 0; b < 4; b++) if (mem_we && mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= sram[mem_addr];
  end

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
    .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
    .m1_rsp_err(m1_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && (m0_rsp_valid || m1_rsp_valid)) begin
    if (q.size() == 0) chk("unexpected_rsp", {m1_rsp_valid, m0_rsp_valid}, 0);
    else begin
      e = q.pop_front();
      chk("rsp_valid", 32'({m1_rsp_valid, m0_rsp_valid}), e.id ? 32'd2 : 32'd1);
      chk("rsp_rdata", e.id ? m1_rdata : m0_rdata, e.rdata);
      chk("rsp_err", 32'(e.id ? m1_rsp_err : m0_rsp_err), 32'(e.err));
      chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      chk("idle_side", e.id ? (m0_rdata | 32'(m0_rsp_err)) : (m1_rdata | 32'(m1_rsp_err)), 0);
    end
  end

  task automatic drive(input logic id, input logic v, input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    if (id) begin
      m1_req_valid = v; m1_we = we; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
    end else begin
      m0_req_valid = v; m0_we = we; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      chk("rsp_timeout", 32'(q.size()), 0);
      q.delete();
    end
  endtask

  task automatic wait_ready(input logic both, input logic id, output logic ok);
    int c = 0;
    while (!(both ? (m0_req_ready | m1_req_ready) : (id ? m1_req_ready : m0_req_ready)) && c < 10) begin
      @(negedge clk); #1; c++;
    end
    ok = both ? (m0_req_ready | m1_req_ready) : (id ? m1_req_ready : m0_req_ready);
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  task automatic run(input vec_t v);
    logic ok;
    @(negedge clk);
    drive(v.id, 1, v.we, v.addr, v.wdata, v.wstrb);
    #1;
    wait_ready(0, v.id, ok);
    if (!ok) begin
      drive(v.id, 0, 0, 0, 0, 0);
      return;
    end
    q.push_back('{v.id, v.rdata, v.err, cyc + (v.err ? 1 : 2)});
    @(negedge clk);
    drive(v.id, 0, 0, 0, 0, 0);
    #1;
    chk("mem_en", 32'(mem_en), 32'(!v.err));
    if (!v.err) begin
      chk("mem_addr", 32'(mem_addr), 32'(v.maddr));
      chk("mem_we", 32'(mem_we), 32'(v.we));
      chk("mem_wdata", mem_wdata, v.wdata);
      chk("mem_wstrb", 32'(mem_wstrb), v.we ? 32'(v.wstrb) : 0);
      @(negedge clk); #1;
      chk("mem_en_resp", 32'(mem_en), 0);
    end
    drain();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 32'({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err, mem_en, mem_we}), 0);
    chk({nm, "_data"}, m0_rdata | m1_rdata | mem_wdata | 32'({mem_addr, mem_wstrb}), 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
  endtask

  task automatic alt(input int n, input logic [31:0] a0, input logic [31:0] e0, input logic [31:0] a1, input logic [31:0] e1);
    logic ok;
    drive(0, 1, 0, a0, 0, 0);
    drive(1, 1, 0, a1, 0, 0);
    #1;
    for (int k = 0; k < n; k++) begin
      wait_ready(1, 0, ok);
      if (!ok) break;
      chk("rr_grant", 32'({m1_req_ready, m0_req_ready}), (k % 2) ? 32'd2 : 32'd1);
      q.push_back('{m1_req_ready, m1_req_ready ? e1 : e0, 1'b0, cyc + 2});
      @(negedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drain();
  endtask

  initial begin
    logic ok;
    for (int i = 0; i < 64; i++) sram[i] = 0;
    mem_rdata = 0;
    tbl[0]  = '{0, 1, 32'hFC,       32'h12345678, 4'hF, 32'h0,        0, 6'd63};
    tbl[1]  = '{0, 0, 32'hFC,       32'h0,        4'h0, 32'h12345678, 0, 6'd63};
    tbl[2]  = '{0, 1, 32'hF8,       32'h0000FFFF, 4'h3, 32'h0,        0, 6'd62};
    tbl[3]  = '{0, 0, 32'hF8,       32'h0,        4'h0, 32'h0000FFFF, 0, 6'd62};
    tbl[4]  = '{1, 0, 32'h100,      32'h0,        4'h0, 32'h0,        1, 6'd0};
    tbl[5]  = '{1, 0, 32'hFC,       32'h0,        4'h0, 32'h12345678, 0, 6'd63};
    tbl[6]  = '{1, 1, 32'h10,       32'hAABBCCDD, 4'hA, 32'h0,        0, 6'd4};
    tbl[7]  = '{0, 0, 32'h10,       32'h0,        4'h0, 32'hAA00CC00, 0, 6'd4};
    tbl[8]  = '{0, 1, 32'hFFFFFFFC, 32'h11111111, 4'hF, 32'h0,        1, 6'd0};
    tbl[9]  = '{1, 1, 32'hFC,       32'h11223344, 4'h1, 32'h0,        0, 6'd63};
    tbl[10] = '{1, 0, 32'hFE,       32'h0,        4'h0, 32'h12345644, 0, 6'd63};
    tbl[11] = '{0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 6'd0};
    do_reset();
    for (int i = 0; i < 12; i++) run(tbl[i]);
    do_reset();
    alt(4, 32'hFC, 32'h12345644, 32'h10, 32'hAA00CC00);
    @(negedge clk);
    drive(0, 1, 1, 32'h20, 32'h55555555, 4'hF);
    #1;
    wait_ready(0, 0, ok);
    @(negedge clk); #1;
    chk("mid_issue_en", 32'(mem_en), 1);
    rst_n = 0;
    #1;
    chk_zero("async_reset");
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    alt(2, 32'h20, 32'h0, 32'h20, 32'h0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
